// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies, FSM states.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Ops that occupy the unit for several cycles.
    function automatic logic is_multi(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply and 32/32 divide producing HI/LO results.
// Latency: 0 cycles (pure combinational; the controller samples it on completion).
// Backpressure: none; results follow the inputs.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div0
);

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);

    // Multiply via sign/zero extension to 64 bits; divide via magnitudes so
    // 0x80000000 / -1 never overflows and the sign rules are applied explicitly.
    always_comb begin
        a_neg  = signed_op & a[31];
        b_neg  = signed_op & b[31];
        a_ext  = {{32{a_neg}}, a};
        b_ext  = {{32{b_neg}}, b};
        prod   = a_ext * b_ext;
        a_mag  = a_neg ? (32'd0 - a) : a;
        b_mag  = b_neg ? (32'd0 - b) : b;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        div0   = is_div(op) && (b == 32'd0);
        hi_res = prod[63:32];
        lo_res = prod[31:0];
        if (is_div(op)) begin
            lo_res = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
            hi_res = a_neg ? (32'd0 - r_mag) : r_mag;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: issue FSM, latency counter, HI/LO registers and E-stage stall.
// Latency: MULT_LAT / DIV_LAT cycles from accept to HI/LO update; MTHI/MTLO write on the accept edge.
// Backpressure: stall_e holds the D/E register while an MD-dependent D-stage op would collide.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall_e,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   lat_sel;
    logic [2:0]         op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic               accept;
    logic               accept_multi;
    logic               last;
    logic [31:0]        hi_res;
    logic [31:0]        lo_res;
    logic               div0;

    assign accept       = start & ~req & (state == ST_IDLE);
    assign accept_multi = accept & is_multi(op);
    assign last         = (state == ST_BUSY) && (cnt == CNT_W'(1));
    assign lat_sel      = is_div(op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    // Arithmetic always works on the operands captured at accept.
    mdu_arith u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .div0   (div0)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state: enter BUSY on a multi-cycle accept, leave when the counter expires.
    always_comb begin
        state_nxt = state;
        if (state == ST_IDLE) begin
            if (accept_multi) state_nxt = ST_BUSY;
        end else begin
            if (last) state_nxt = ST_IDLE;
        end
    end

    // FSM outputs.
    always_comb begin
        busy = (state == ST_BUSY);
    end

    // Latency counter and operand latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= 3'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (accept_multi) begin
            cnt  <= lat_sel;
            op_q <= op;
            a_q  <= rs_val;
            b_q  <= rt_val;
        end else if ((state == ST_BUSY) && (cnt != '0)) begin
            cnt  <= cnt - CNT_W'(1);
        end
    end

    // HI/LO: result write on completion (skipped for divide by zero), direct move on MTHI/MTLO accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (last) begin
            if (!div0) begin
                hi <= hi_res;
                lo <= lo_res;
            end
        end else if (accept) begin
            if (op == OP_MTHI) hi <= rs_val;
            if (op == OP_MTLO) lo <= rs_val;
        end
    end

    // Stall the E stage while a dependent D-stage op would see stale HI/LO or a busy unit.
    assign stall_e = d_uses_md & (busy | (start & ~req & is_multi(op)));

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_uses_md;
    logic        busy;
    logic        stall_e;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          acc;
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .d_uses_md (d_uses_md),
        .busy      (busy),
        .stall_e   (stall_e),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!reset) assert (!(start && busy)) else $error("protocol violation: start while busy");
    end

    // Monitor: busy/stall every cycle, HI/LO whenever a scoreboard entry falls due.
    always @(negedge clk) begin
        logic eb;
        logic es;
        logic mc;
        exp_t e;
        eb = (sb.size() > 0) && (sb[0].acc <= cyc) && (cyc < sb[0].due);
        mc = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        es = d_uses_md & (eb | (start & ~req & mc));
        checks++;
        if (busy !== eb) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, eb);
        end
        checks++;
        if (stall_e !== es) begin
            errors++;
            $display("FAIL stall_e cyc=%0d got=%b want=%b", cyc, stall_e, es);
        end
        while ((sb.size() > 0) && (sb[0].due == cyc)) begin
            e = sb.pop_front();
            checks++;
            if ((hi !== e.hi) || (lo !== e.lo)) begin
                errors++;
                $display("FAIL hilo cyc=%0d got hi=%h lo=%h want hi=%h lo=%h", cyc, hi, lo, e.hi, e.lo);
            end
        end
    end

    // Reference model: result of one op given the architectural HI/LO before it.
    task automatic ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      x, y, q, r;
        logic [63:0] p;
        case (o)
            OP_MULT: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_DIV: if (b != 0) begin
                x = longint'($signed(a)); y = longint'($signed(b));
                q = x / y; r = x % y;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            OP_DIVU: if (b != 0) begin
                m_lo = a / b; m_hi = a % b;
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op; dmd 0/1 holds d_uses_md, 2 randomises it each cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit rq, input int dmd);
        int k, lat, due;
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_val = a; rt_val = b; req = rq;
        d_uses_md = (dmd == 2) ? 1'($urandom_range(0, 1)) : (dmd != 0);
        k   = cyc;
        lat = 0;
        if (!rq) begin
            if (o == OP_MULT || o == OP_MULTU) lat = ML;
            else if (o == OP_DIV || o == OP_DIVU) lat = DL;
            ref_op(o, a, b);
        end
        due = k + 1 + lat;
        sb.push_back('{k + 1, due, m_hi, m_lo});
        @(posedge clk); #1;
        start = 1'b0; req = 1'b0;
        while (cyc < due) begin
            rs_val = $urandom; rt_val = $urandom;
            req = ($urandom_range(0, 3) == 0);
            if (dmd == 2) d_uses_md = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        req = 1'b0;
    endtask

    // DIV accepted, then reset asserted during busy cycle 4: no late write afterwards.
    task automatic reset_mid_div(input logic [31:0] a, input logic [31:0] b);
        int k, due;
        @(posedge clk); #1;
        start = 1'b1; op = OP_DIV; rs_val = a; rt_val = b; req = 1'b0; d_uses_md = 1'b1;
        k   = cyc;
        due = k + 1 + DL;
        sb.push_back('{k + 1, due, m_hi, m_lo});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        m_hi = 32'd0; m_lo = 32'd0;
        sb.push_back('{cyc, cyc, 32'd0, 32'd0});
        sb.push_back('{due, due, 32'd0, 32'd0});
        while (cyc < due) begin
            rs_val = $urandom; rt_val = $urandom;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; req = 1'b0; op = 3'd0;
        rs_val = 32'd0; rt_val = 32'd0; d_uses_md = 1'b0;
        sb.push_back('{1, 1, 32'd0, 32'd0});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        issue(OP_MULT,  32'hFFFFFFFE, 32'd3,        1'b0, 1);
        issue(OP_DIVU,  32'd100,      32'd7,        1'b0, 2);
        issue(OP_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 2);
        issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 2);
        issue(OP_MTHI,  32'h1234,     32'd0,        1'b1, 2);
        issue(OP_MTHI,  32'h1234,     32'd0,        1'b0, 2);
        issue(OP_MTHI,  32'd5,        32'd0,        1'b0, 2);
        issue(OP_MTLO,  32'd6,        32'd0,        1'b0, 2);
        issue(OP_DIV,   32'd123,      32'd0,        1'b0, 1);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2);
        issue(OP_MULT,  32'd123,      32'd456,      1'b1, 1);
        issue(OP_DIVU,  32'hDEADBEEF, 32'd0,        1'b0, 0);
        reset_mid_div(32'd1000, 32'd3);

        for (int i = 0; i < 80; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 16));
                3:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) begin
                ro = OP_DIV; ra = 32'h80000000; rb = 32'hFFFFFFFF;
            end
            issue(ro, ra, rb, ($urandom_range(0, 7) == 0), 2);
        end

        @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
